// File: rtl/piso_shift_tx_if.sv
// Load handshake, shift enable and serial output bundle
// for the PISO shift transmitter.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             load_valid;
    logic             load_ready;
    logic             en;
    logic             Q;
    logic             q_valid;
    logic             done;

    modport master (
        output D, load_valid, en,
        input  load_ready, Q, q_valid, done
    );

    modport slave (
        input  D, load_valid, en,
        output load_ready, Q, q_valid, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: LSB first, one bit
// per enabled clock, back-to-back frames without a gap.
module piso_shift_tx #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    piso_shift_tx_if.slave       bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic last;
    logic ready;
    logic accept;

    assign last   = (state_q == SHIFT) & bus.en & (cnt_q == LAST);
    assign ready  = (state_q == IDLE) | last;
    assign accept = bus.load_valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: if (last && !bus.load_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A load in the last-bit cycle reloads in place of the drain.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        done_d = last;
        if (accept) begin
            sreg_d = bus.D;
            cnt_d  = '0;
        end else if (last) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if ((state_q == SHIFT) && bus.en) begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.load_ready = ready;
        bus.Q          = sreg_q[0];
        bus.q_valid    = (state_q == SHIFT);
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed scenarios
// plus random traffic against a word/bit-index model.
module tb_piso_shift_tx;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    piso_shift_tx_if #(.WIDTH(W)) bus ();

    piso_shift_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: frame in flight as a word plus the index of the bit on Q.
    bit           m_busy;
    logic [W-1:0] m_word;
    int           m_idx;
    bit           m_done;
    logic [W-1:0] sentq[$];
    logic [W-1:0] rx;
    int           rx_n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0;
        m_word = '0;
        m_idx  = 0;
        m_done = 0;
        rx     = '0;
        rx_n   = 0;
        sentq.delete();
    endtask

    task automatic cycle(input logic lv, input logic [W-1:0] d,
                         input logic e);
        logic exp_q;
        bit   rdy;
        @(negedge clk);
        bus.load_valid = lv;
        bus.D          = d;
        bus.en         = e;
        #1;
        exp_q = m_busy ? m_word[m_idx] : 1'b0;
        rdy   = !m_busy || (e && m_idx == W - 1);
        chk("q", 32'(bus.Q), 32'(exp_q));
        chk("q_valid", 32'(bus.q_valid), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("load_ready", 32'(bus.load_ready), 32'(rdy));
        // Consumer side: rebuild each frame from Q and compare on done.
        if (bus.done === 1'b1) begin
            if (sentq.size() > 0) begin
                chk("frame", 32'(rx), 32'(sentq.pop_front()));
            end else begin
                chk("frame_unexpected", 32'(bus.done), 32'(0));
            end
            rx_n = 0;
        end
        if (bus.q_valid === 1'b1 && e) begin
            rx = {bus.Q, rx[W-1:1]};
            rx_n++;
        end
        m_done = m_busy && e && (m_idx == W - 1);
        if (m_busy && e) begin
            if (m_idx == W - 1) begin
                if (lv) begin
                    m_word = d;
                    m_idx  = 0;
                    sentq.push_back(d);
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_idx++;
            end
        end else if (!m_busy && lv) begin
            m_busy = 1;
            m_word = d;
            m_idx  = 0;
            sentq.push_back(d);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(bus.Q), 32'(0));
        chk("rst_q_valid", 32'(bus.q_valid), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_load_ready", 32'(bus.load_ready), 32'(1));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.D          = '0;
        bus.en         = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        chk("reset_q", 32'(bus.Q), 32'(0));
        chk("reset_q_valid", 32'(bus.q_valid), 32'(0));
        chk("reset_done", 32'(bus.done), 32'(0));
        chk("reset_load_ready", 32'(bus.load_ready), 32'(1));
        rst_n = 1'b1;

        // Single frame
        cycle(1'b1, 4'b0100, 1'b1);
        repeat (6) cycle(1'b0, 4'b0000, 1'b1);

        // Stalled frame; en in idle is ignored
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        repeat (3) cycle(1'b0, 4'b0000, 1'b1);

        // Back-to-back frames
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        repeat (6) cycle(1'b0, 4'b0000, 1'b1);

        // Load attempts while busy are ignored
        cycle(1'b1, 4'b0001, 1'b1);
        repeat (3) cycle(1'b1, 4'b1111, 1'b1);
        repeat (3) cycle(1'b0, 4'b0000, 1'b1);

        // Reset mid-frame, then a clean frame
        cycle(1'b1, 4'b1010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        async_reset();
        cycle(1'b1, 4'b0011, 1'b1);
        repeat (6) cycle(1'b0, 4'b0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        repeat (12) cycle(1'b0, 4'b0000, 1'b1);
        chk("frames_drained", 32'(sentq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
